// File: rtl/execute_pipe_skid.sv
// EX/MEM pipeline register with a valid/ready handshake on both sides.
// A 2-entry skid buffer absorbs back-pressure. Side-effect enables are masked on bubbles.
module execute_pipe_skid #(
  parameter int PC_WIDTH       = 20,
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      mem_data_rd_en_in,
  input  logic                      mem_data_wr_en_in,
  input  logic [DATA_WIDTH-1:0]     mem_data_in,
  input  logic [DATA_WIDTH-1:0]     alu_data_in,
  input  logic                      reg_wr_en_in,
  input  logic [REG_ADDR_WIDTH-1:0] reg_wr_addr_in,
  input  logic                      write_back_mux_sel_in,
  input  logic                      select_new_pc_in,
  input  logic [PC_WIDTH-1:0]       new_pc_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      mem_data_rd_en_out,
  output logic                      mem_data_wr_en_out,
  output logic [DATA_WIDTH-1:0]     mem_data_out,
  output logic [DATA_WIDTH-1:0]     alu_data_out,
  output logic                      reg_wr_en_out,
  output logic [REG_ADDR_WIDTH-1:0] reg_wr_addr_out,
  output logic                      write_back_mux_sel_out,
  output logic                      select_new_pc_out,
  output logic [PC_WIDTH-1:0]       new_pc_out,
  output logic [1:0]                occupancy,
  output logic [CNT_WIDTH-1:0]      stall_cycles
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  typedef struct packed {
    logic                      rd_en;
    logic                      wr_en;
    logic [DATA_WIDTH-1:0]     mem_data;
    logic [DATA_WIDTH-1:0]     alu_data;
    logic                      reg_wr_en;
    logic [REG_ADDR_WIDTH-1:0] reg_wr_addr;
    logic                      wb_sel;
    logic                      sel_pc;
    logic [PC_WIDTH-1:0]       new_pc;
  } entry_t;

  state_t               state_q, state_d;
  entry_t               head_q, head_d;
  entry_t               skid_q, skid_d;
  entry_t               in_entry;
  logic                 in_ready_q;
  logic                 out_valid_q;
  logic [1:0]           occ_q;
  logic [CNT_WIDTH-1:0] stall_q, stall_d;
  logic                 in_fire;
  logic                 out_fire;

  assign in_entry = '{
    rd_en:       mem_data_rd_en_in,
    wr_en:       mem_data_wr_en_in,
    mem_data:    mem_data_in,
    alu_data:    alu_data_in,
    reg_wr_en:   reg_wr_en_in,
    reg_wr_addr: reg_wr_addr_in,
    wb_sel:      write_back_mux_sel_in,
    sel_pc:      select_new_pc_in,
    new_pc:      new_pc_in
  };

  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = out_valid_q & out_ready;

  // Next state and payload moves; flush drops everything but leaves payload intact.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d = ONE;
            head_d  = in_entry;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            head_d = in_entry;
          end else if (in_fire) begin
            state_d = TWO;
            skid_d  = in_entry;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (out_fire) begin
            state_d = ONE;
            head_d  = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // State, payload and registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      head_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      occ_q       <= 2'd0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      skid_q      <= skid_d;
      in_ready_q  <= (state_d != TWO);
      out_valid_q <= (state_d != EMPTY);
      occ_q       <= state_d;
    end
  end

  // Saturating count of cycles the head was held by the consumer.
  always_comb begin
    stall_d = stall_q;
    if (out_valid_q && !out_ready && (stall_q != '1)) begin
      stall_d = stall_q + 1'b1;
    end
  end

  // Stall counter register; only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign in_ready               = in_ready_q;
  assign out_valid              = out_valid_q;
  assign occupancy              = occ_q;
  assign stall_cycles           = stall_q;
  assign mem_data_rd_en_out     = head_q.rd_en & out_valid_q;
  assign mem_data_wr_en_out     = head_q.wr_en & out_valid_q;
  assign reg_wr_en_out          = head_q.reg_wr_en & out_valid_q;
  assign select_new_pc_out      = head_q.sel_pc & out_valid_q;
  assign mem_data_out           = head_q.mem_data;
  assign alu_data_out           = head_q.alu_data;
  assign reg_wr_addr_out        = head_q.reg_wr_addr;
  assign write_back_mux_sel_out = head_q.wb_sel;
  assign new_pc_out             = head_q.new_pc;

endmodule

// File: tb/tb_execute_pipe_skid.sv
// Scoreboard bench for execute_pipe_skid.
// A queue model tracks accepted entries; a negedge monitor compares head and status.
module tb_execute_pipe_skid;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [31:0] mdata;
    logic [31:0] alu;
    logic        rwe;
    logic [4:0]  raddr;
    logic        wb;
    logic        sel;
    logic [19:0] pc;
  } entry_t;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic        rd_i, wr_i, rwe_i, wb_i, sel_i;
  logic [31:0] mdata_i, alu_i;
  logic [4:0]  raddr_i;
  logic [19:0] pc_i;
  logic        out_valid;
  logic        out_ready;
  logic        rd_o, wr_o, rwe_o, wb_o, sel_o;
  logic [31:0] mdata_o, alu_o;
  logic [4:0]  raddr_o;
  logic [19:0] pc_o;
  logic [1:0]  occupancy;
  logic [3:0]  stall_cycles;

  int checks = 0;
  int errors = 0;

  entry_t q[$];
  int     stall_m = 0;
  logic   inrdy_m = 1'b0;

  execute_pipe_skid #(
    .PC_WIDTH(20), .DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .CNT_WIDTH(4)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .mem_data_rd_en_in(rd_i), .mem_data_wr_en_in(wr_i),
    .mem_data_in(mdata_i), .alu_data_in(alu_i),
    .reg_wr_en_in(rwe_i), .reg_wr_addr_in(raddr_i),
    .write_back_mux_sel_in(wb_i), .select_new_pc_in(sel_i),
    .new_pc_in(pc_i),
    .out_valid(out_valid), .out_ready(out_ready),
    .mem_data_rd_en_out(rd_o), .mem_data_wr_en_out(wr_o),
    .mem_data_out(mdata_o), .alu_data_out(alu_o),
    .reg_wr_en_out(rwe_o), .reg_wr_addr_out(raddr_o),
    .write_back_mux_sel_out(wb_o), .select_new_pc_out(sel_o),
    .new_pc_out(pc_o),
    .occupancy(occupancy), .stall_cycles(stall_cycles)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, exp);
    end
  endtask

  function automatic entry_t mk(input logic [31:0] alu, input logic en,
                                input logic sel, input logic [19:0] pc);
    entry_t e;
    e.rd    = en & alu[0];
    e.wr    = en;
    e.mdata = alu ^ 32'h5555_0000;
    e.alu   = alu;
    e.rwe   = en;
    e.raddr = alu[4:0] + 5'd3;
    e.wb    = alu[1];
    e.sel   = sel;
    e.pc    = pc;
    return e;
  endfunction

  task automatic put(input logic v, input entry_t e);
    in_valid = v;
    rd_i     = e.rd;
    wr_i     = e.wr;
    mdata_i  = e.mdata;
    alu_i    = e.alu;
    rwe_i    = e.rwe;
    raddr_i  = e.raddr;
    wb_i     = e.wb;
    sel_i    = e.sel;
    pc_i     = e.pc;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: compare DUT against the queue model, then advance the model.
  always @(negedge clk) begin
    entry_t h;
    entry_t cur;
    logic   acc;
    if (rst) begin
      q.delete();
      stall_m = 0;
      inrdy_m = 1'b0;
    end
    chk("in_ready", {63'd0, in_ready}, {63'd0, inrdy_m});
    chk("out_valid", {63'd0, out_valid}, {63'd0, q.size() > 0});
    chk("occupancy", {62'd0, occupancy}, 64'(q.size()));
    chk("stall_cycles", {60'd0, stall_cycles}, 64'(stall_m));
    if (q.size() > 0) begin
      h = q[0];
      chk("alu_data_out", {32'd0, alu_o}, {32'd0, h.alu});
      chk("mem_data_out", {32'd0, mdata_o}, {32'd0, h.mdata});
      chk("reg_wr_addr_out", {59'd0, raddr_o}, {59'd0, h.raddr});
      chk("wb_sel_out", {63'd0, wb_o}, {63'd0, h.wb});
      chk("new_pc_out", {44'd0, pc_o}, {44'd0, h.pc});
      chk("enables_out", {60'd0, rd_o, wr_o, rwe_o, sel_o},
          {60'd0, h.rd, h.wr, h.rwe, h.sel});
    end else begin
      chk("bubble_enables", {60'd0, rd_o, wr_o, rwe_o, sel_o}, 64'd0);
    end
    if (!rst) begin
      cur = '{rd_i, wr_i, mdata_i, alu_i, rwe_i, raddr_i, wb_i, sel_i, pc_i};
      if (q.size() > 0 && !out_ready && stall_m < 15) stall_m++;
      acc = in_valid & inrdy_m;
      if (flush) begin
        q.delete();
      end else begin
        if (q.size() > 0 && out_ready) void'(q.pop_front());
        if (acc) q.push_back(cur);
      end
      inrdy_m = (q.size() < 2);
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout actual running required finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b1;
    put(1'b0, '0);
    cyc(2);
    rst = 1'b0;
    cyc(2);

    // streaming 1, 2, 3
    for (int i = 1; i <= 3; i++) begin
      put(1'b1, mk(32'(i), 1'b1, 1'b0, 20'h0));
      cyc(1);
    end
    put(1'b0, '0);
    cyc(3);

    // back-pressure fill, C held while full
    out_ready = 1'b0;
    put(1'b1, mk(32'hA, 1'b1, 1'b0, 20'h0));
    cyc(1);
    put(1'b1, mk(32'hB, 1'b0, 1'b0, 20'h0));
    cyc(1);
    put(1'b1, mk(32'hC, 1'b1, 1'b0, 20'h0));
    cyc(3);
    out_ready = 1'b1;
    cyc(2);
    put(1'b0, '0);
    cyc(3);

    // flush with side-effect entry held
    out_ready = 1'b0;
    put(1'b1, mk(32'h40, 1'b1, 1'b1, 20'h00777));
    cyc(1);
    put(1'b1, mk(32'h41, 1'b1, 1'b0, 20'h0));
    flush = 1'b1;
    cyc(1);
    flush = 1'b0;
    put(1'b0, '0);
    cyc(2);

    // redirect pass-through
    out_ready = 1'b1;
    put(1'b1, mk(32'h50, 1'b0, 1'b1, 20'h12345));
    cyc(1);
    put(1'b0, '0);
    cyc(3);

    // counter saturation, flush keeps count, reset clears it
    out_ready = 1'b0;
    put(1'b1, mk(32'h60, 1'b1, 1'b0, 20'h0));
    cyc(1);
    put(1'b0, '0);
    cyc(20);
    flush = 1'b1;
    cyc(1);
    flush = 1'b0;
    cyc(2);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    cyc(2);

    // asynchronous reset while full
    out_ready = 1'b0;
    put(1'b1, mk(32'h71, 1'b1, 1'b1, 20'h1));
    cyc(1);
    put(1'b1, mk(32'h73, 1'b1, 1'b1, 20'h2));
    cyc(1);
    put(1'b0, '0);
    cyc(2);
    #2;
    rst = 1'b1;
    #1;
    chk("async_out_valid", {63'd0, out_valid}, 64'd0);
    chk("async_occupancy", {62'd0, occupancy}, 64'd0);
    chk("async_enables", {60'd0, rd_o, wr_o, rwe_o, sel_o}, 64'd0);
    chk("async_in_ready", {63'd0, in_ready}, 64'd0);
    chk("async_stall", {60'd0, stall_cycles}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/execute_pipe_skid.md
Name: execute_pipe_skid

Overview:
- Parametrised, back-pressure-capable EX/MEM pipeline register with a valid/ready handshake on both sides and a 2-entry skid buffer.
- Sits between the execute stage and the memory stage. It carries the same payload as the plain EX/MEM register: memory enables, memory data, ALU result, register write controls, write-back mux select, and the new-PC redirect.
- Adds stall handling, flush, bubble masking of side-effect controls, and a saturating stall-cycle counter.

Parameters:
- PC_WIDTH, 20, width of new_pc.
- DATA_WIDTH, 32, width of mem_data and alu_data.
- REG_ADDR_WIDTH, 5, width of the register-file write address.
- CNT_WIDTH, 16, width of the stall-cycle counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous kill of all held and incoming entries.
- in_valid  input  1  upstream entry valid.
- in_ready  output  1  buffer can accept an entry; registered.
- mem_data_rd_en_in  input  1  memory read enable.
- mem_data_wr_en_in  input  1  memory write enable.
- mem_data_in  input  DATA_WIDTH  memory write data.
- alu_data_in  input  DATA_WIDTH  ALU result / memory address.
- reg_wr_en_in  input  1  register write enable.
- reg_wr_addr_in  input  REG_ADDR_WIDTH  register write address.
- write_back_mux_sel_in  input  1  write-back source select.
- select_new_pc_in  input  1  PC redirect request.
- new_pc_in  input  PC_WIDTH  redirect target.
- out_valid  output  1  output entry valid.
- out_ready  input  1  downstream accepts the entry.
- *_out  output  (same widths as *_in)  registered payload of the head entry, one output per input field above.
- occupancy  output  2  entries held (0..2).
- stall_cycles  output  CNT_WIDTH  saturating count of back-pressured cycles.

Behaviour:
- Reset (asynchronous, active-high): all of the following are 0 while rst is high and after release:
  - state = EMPTY; out_valid = 0; occupancy = 0; stall_cycles = 0.
  - All payload registers (head and skid) cleared to 0.
  - in_ready = 1 from the first edge after release (0 while rst is high).
- Handshake definitions:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - in_valid is ignored when in_ready = 0; upstream must hold its payload.
- Storage: a head register drives the outputs; a skid register holds a second entry.
- State machine, evaluated at the clock edge:
  - EMPTY: in_fire -> ONE, head <= in.
  - ONE: in_fire & out_fire -> ONE, head <= in. in_fire only -> TWO, skid <= in. out_fire only -> EMPTY. Neither -> stay.
  - TWO: out_fire -> ONE, head <= skid. Otherwise stay. in_ready = 0 throughout.
- Register-driven outputs:
  - in_ready registered: 1 when the next state is EMPTY or ONE, 0 when it is TWO.
  - out_valid = (state != EMPTY), registered. occupancy encodes the state as 0, 1 or 2.
- Latency and throughput:
  - An entry accepted at edge N is visible on the outputs after edge N when the buffer was EMPTY, or when ONE with out_fire in the same cycle.
  - Full throughput of 1 entry per cycle while out_ready = 1.
- Flush (priority over every handshake):
  - At the edge, state <= EMPTY and in_ready <= 1.
  - An in_fire in the same cycle is discarded; an out_fire in the same cycle is still considered consumed downstream.
  - Payload registers are not cleared.
- Bubble masking:
  - mem_data_rd_en_out, mem_data_wr_en_out, reg_wr_en_out and select_new_pc_out are ANDed combinationally with out_valid.
  - A bubble or flushed slot therefore never produces a side effect.
  - Data outputs hold their last value while out_valid = 0.
- Ordering: entries leave strictly in acceptance order; the skid entry never overtakes the head.
- stall_cycles:
  - Increments on every edge where out_valid & ~out_ready.
  - Saturates at 2^CNT_WIDTH-1 and does not wrap.
  - Cleared only by rst; flush does not clear it.
- Reset mid-operation: the asynchronous clear takes effect immediately, regardless of state or in-flight handshakes.

Test Plan:
- Reset then streaming:
  - Stimulus: rst pulse; in_valid=1, out_ready=1; alu_data_in = 1, 2, 3 on consecutive cycles.
  - Required: alu_data_out = 1, 2, 3 on consecutive cycles with out_valid=1; occupancy=1; stall_cycles=0.
- Back-pressure fill:
  - Stimulus: out_ready=0; push A=0xA, then B=0xB.
  - Required: occupancy=2; in_ready=0; head holds 0xA; C (0xC) presented with in_valid held is not accepted.
  - Stimulus: raise out_ready.
  - Required: outputs 0xA, 0xB, 0xC in order; no loss, no duplicate.
- Flush with side effects:
  - Stimulus: buffer holds an entry with reg_wr_en=1 and mem_data_wr_en=1; assert flush for 1 cycle while in_valid=1.
  - Required next cycle: out_valid=0; reg_wr_en_out=0; mem_data_wr_en_out=0; select_new_pc_out=0; occupancy=0; in_ready=1; the incoming entry does not appear.
- Redirect pass-through:
  - Stimulus: select_new_pc_in=1, new_pc_in=0x12345.
  - Required: select_new_pc_out=1 and new_pc_out=0x12345 for exactly the cycle(s) the entry is valid at the head; 0 afterwards when the buffer is empty.
- Counter saturation:
  - Stimulus: CNT_WIDTH=4; out_valid held with out_ready=0 for 20 cycles.
  - Required: stall_cycles reaches 15 and stays at 15; flush does not clear it; rst returns it to 0.
- Asynchronous reset mid-stall:
  - Stimulus: occupancy=2; assert rst between clock edges.
  - Required: out_valid, occupancy and all enable outputs go to 0 immediately, without waiting for a clock edge.
